at89c2051_dut_model: RTL and testbench

- Synthesizable responder model of the AT89C2051 flash-programming interface: the chip end of the programmer bottomhalf.
- Samples the mode pins (P3.3/P3.4/P3.5/P3.7), the XTAL1 address-increment pulse, the P3.2 PROG pulse and VPP/RST.
- Stores code bytes, drives P1 on reads and drives the RDY/BSY line on P3.1.
- Used in the loopback test bitstream and in simulation benches to close the loop on programmer bitstreams without silicon.

---
 rtl/at89c2051_pkg.sv | 56 +++++
 rtl/at89c2051_dut_model_pin_sync_edge.sv | 34 +++
 rtl/at89c2051_dut_model.sv | 223 ++++++++++++++++++++++
 tb/tb_at89c2051_dut_model.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/at89c2051_pkg.sv
// Shared types and constants for the AT89C2051 flash-programming model.
// Timing defaults are also consumed by the programmer bottomhalf.
package at89c2051_pkg;

    localparam int MEM_DEPTH_DEF    = 2048;
    localparam int ADDR_W_DEF       = 11;
    localparam int WRITE_CYCLES_DEF = 24;
    localparam int ERASE_MIN_DEF    = 240;

    localparam logic [7:0] SIG0_DEF = 8'h1E;
    localparam logic [7:0] SIG1_DEF = 8'h21;

    typedef enum logic [2:0] {
        MODE_NONE,
        MODE_WRITE,
        MODE_READ,
        MODE_LOCK1,
        MODE_LOCK2,
        MODE_ERASE,
        MODE_SIG
    } mode_e;

    // Pin order is {p33, p34, p35, p37}
    localparam logic [3:0] PINS_WRITE = 4'b1011;
    localparam logic [3:0] PINS_READ  = 4'b0011;
    localparam logic [3:0] PINS_LOCK1 = 4'b1111;
    localparam logic [3:0] PINS_LOCK2 = 4'b1100;
    localparam logic [3:0] PINS_ERASE = 4'b1000;
    localparam logic [3:0] PINS_SIG   = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE_BUSY,
        ST_ERASE_WAIT,
        ST_ERASE_SWEEP
    } state_e;

    function automatic mode_e decode_mode(input logic vpp,
                                          input logic [3:0] pins);
        mode_e m;
        m = MODE_NONE;
        if (vpp) begin
            case (pins)
                PINS_WRITE: m = MODE_WRITE;
                PINS_READ:  m = MODE_READ;
                PINS_LOCK1: m = MODE_LOCK1;
                PINS_LOCK2: m = MODE_LOCK2;
                PINS_ERASE: m = MODE_ERASE;
                PINS_SIG:   m = MODE_SIG;
                default:    m = MODE_NONE;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/at89c2051_dut_model_pin_sync_edge.sv
// Two-flop synchroniser with a previous-value stage for edge pulses.
module pin_sync_edge #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/at89c2051_dut_model.sv
// Chip-side responder for the AT89C2051 parallel flash-programming protocol.
// Stores code bytes, serves reads/signature, and models busy timing on RDY.
module at89c2051_dut_model
    import at89c2051_pkg::*;
#(
    parameter int         MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter int         ADDR_W       = ADDR_W_DEF,
    parameter int         WRITE_CYCLES = WRITE_CYCLES_DEF,
    parameter int         ERASE_MIN    = ERASE_MIN_DEF,
    parameter logic [7:0] SIG0         = SIG0_DEF,
    parameter logic [7:0] SIG1         = SIG1_DEF
) (
    input  logic              osc,
    input  logic              rst_n,
    input  logic              vpp,
    input  logic              xtal1,
    input  logic              prog_n,
    input  logic              p33,
    input  logic              p34,
    input  logic              p35,
    input  logic              p37,
    input  logic [7:0]        p1_in,
    output logic [7:0]        p1_out,
    output logic              p1_oe,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    output logic              err
);

    localparam int CNT_W = 16;

    logic       vpp_s, vpp_rise, unused_vpp_fall;
    logic       unused_xtal_q, xtal_rise, unused_xtal_fall;
    logic       unused_prog_q, prog_rise, prog_fall;
    logic [3:0] pins_s, unused_pins_rise, unused_pins_fall;
    logic [7:0] p1_s, unused_p1_rise, unused_p1_fall;

    pin_sync_edge #(.WIDTH(1), .RST_VAL(1'b0)) u_vpp (
        .clk(osc), .rst_n(rst_n), .d(vpp),
        .q(vpp_s), .rise(vpp_rise), .fall(unused_vpp_fall)
    );

    pin_sync_edge #(.WIDTH(1), .RST_VAL(1'b0)) u_xtal (
        .clk(osc), .rst_n(rst_n), .d(xtal1),
        .q(unused_xtal_q), .rise(xtal_rise), .fall(unused_xtal_fall)
    );

    // PROG idles high; resetting to 1 avoids a spurious edge after reset
    pin_sync_edge #(.WIDTH(1), .RST_VAL(1'b1)) u_prog (
        .clk(osc), .rst_n(rst_n), .d(prog_n),
        .q(unused_prog_q), .rise(prog_rise), .fall(prog_fall)
    );

    pin_sync_edge #(.WIDTH(4), .RST_VAL(4'h0)) u_pins (
        .clk(osc), .rst_n(rst_n), .d({p33, p34, p35, p37}),
        .q(pins_s), .rise(unused_pins_rise), .fall(unused_pins_fall)
    );

    pin_sync_edge #(.WIDTH(8), .RST_VAL(8'h00)) u_p1 (
        .clk(osc), .rst_n(rst_n), .d(p1_in),
        .q(p1_s), .rise(unused_p1_rise), .fall(unused_p1_fall)
    );

    mode_e mode;
    assign mode = decode_mode(vpp_s, pins_s);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [7:0]        wd_q, wd_d;
    logic              wen_q, wen_d;
    logic              lock1_q, lock1_d;
    logic              lock2_q, lock2_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [7:0]        mem_wd;
    logic [7:0]        mem_q;
    logic              oe_q, rd_q;
    logic [7:0]        sig_q;

    logic [7:0] mem [MEM_DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wen_d   = wen_q;
        lock1_d = lock1_q;
        lock2_d = lock2_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        mem_wa  = wa_q;
        mem_wd  = wd_q;

        if (prog_fall && (state_q != ST_IDLE || mode == MODE_NONE))
            err_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (prog_fall) begin
                    case (mode)
                        MODE_WRITE: begin
                            state_d = ST_WRITE_BUSY;
                            cnt_d   = CNT_W'(WRITE_CYCLES);
                            wa_d    = addr_q;
                            wd_d    = p1_s;
                            wen_d   = !lock1_q;
                        end
                        MODE_LOCK1: lock1_d = 1'b1;
                        MODE_LOCK2: begin
                            lock1_d = 1'b1;
                            lock2_d = 1'b1;
                        end
                        MODE_ERASE: begin
                            state_d = ST_ERASE_WAIT;
                            cnt_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE_BUSY: begin
                // Final cycle is the one whose decrement reaches zero
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    mem_we  = wen_q;
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE_WAIT: begin
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
                if (prog_rise) begin
                    if (cnt_q >= CNT_W'(ERASE_MIN)) begin
                        state_d = ST_ERASE_SWEEP;
                        wa_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERASE_SWEEP: begin
                mem_we = 1'b1;
                mem_wd = 8'hFF;
                wa_d   = wa_q + ADDR_W'(1);
                if (wa_q == ADDR_W'(MEM_DEPTH - 1)) begin
                    lock1_d = 1'b0;
                    lock2_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            wen_q   <= 1'b0;
            lock1_q <= 1'b0;
            lock2_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wen_q   <= wen_d;
            lock1_q <= lock1_d;
            lock2_q <= lock2_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n)
            addr_q <= '0;
        else if (vpp_rise)
            addr_q <= '0;
        else if (xtal_rise && state_q != ST_ERASE_SWEEP)
            addr_q <= addr_q + ADDR_W'(1);
    end

    // Array is deliberately not reset so an aborted sweep leaves partial data
    always_ff @(posedge osc) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
        mem_q <= mem[addr_q];
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            oe_q  <= 1'b0;
            rd_q  <= 1'b0;
            sig_q <= 8'h00;
        end else begin
            oe_q <= (mode == MODE_READ) || (mode == MODE_SIG);
            rd_q <= (mode == MODE_READ);
            if (addr_q == ADDR_W'(0))
                sig_q <= SIG0;
            else if (addr_q == ADDR_W'(1))
                sig_q <= SIG1;
            else
                sig_q <= 8'hFF;
        end
    end

    assign p1_oe  = oe_q;
    assign p1_out = !oe_q ? 8'h00
                  : !rd_q ? sig_q
                  : lock2_q ? 8'hFF
                  : mem_q;
    assign rdy    = (state_q != ST_WRITE_BUSY) && (state_q != ST_ERASE_SWEEP);
    assign addr   = addr_q;
    assign err    = err_q;

endmodule

// File: tb/tb_at89c2051_dut_model.sv
// Directed bench for the AT89C2051 programming responder.
module tb_at89c2051_dut_model;

    localparam logic [3:0] M_WRITE = 4'b1011;
    localparam logic [3:0] M_READ  = 4'b0011;
    localparam logic [3:0] M_LOCK1 = 4'b1111;
    localparam logic [3:0] M_LOCK2 = 4'b1100;
    localparam logic [3:0] M_ERASE = 4'b1000;
    localparam logic [3:0] M_SIG   = 4'b0000;

    logic        osc = 1'b0;
    logic        rst_n, vpp, xtal1, prog_n;
    logic        p33, p34, p35, p37;
    logic [7:0]  p1_in, p1_out;
    logic        p1_oe, rdy, err;
    logic [10:0] addr;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;
    int n;

    at89c2051_dut_model dut (
        .osc(osc), .rst_n(rst_n), .vpp(vpp), .xtal1(xtal1),
        .prog_n(prog_n), .p33(p33), .p34(p34), .p35(p35), .p37(p37),
        .p1_in(p1_in), .p1_out(p1_out), .p1_oe(p1_oe), .rdy(rdy),
        .addr(addr), .err(err)
    );

    always #5 osc = ~osc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge osc);
        #1;
    endtask

    task automatic set_mode(input logic [3:0] m);
        {p33, p34, p35, p37} = m;
    endtask

    task automatic pulse_prog(input int low);
        prog_n = 1'b0;
        tick(low);
        prog_n = 1'b1;
    endtask

    task automatic goto(input int t);
        while (cur != t) begin
            xtal1 = 1'b1;
            tick(2);
            xtal1 = 1'b0;
            tick(2);
            cur = (cur + 1) % 2048;
        end
        tick(2);
    endtask

    task automatic vpp_restart();
        vpp = 1'b0;
        tick(5);
        vpp = 1'b1;
        tick(5);
        cur = 0;
    endtask

    // Cycles with rdy low; 0 if rdy never drops within 20 cycles
    task automatic count_busy(input int budget, output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge osc);
            if (!rdy) break;
        end
        while (!rdy && cnt < budget) begin
            cnt++;
            @(negedge osc);
        end
        tick(1);
    endtask

    task automatic do_write(input int a, input logic [7:0] d,
                            output int busy);
        goto(a);
        set_mode(M_WRITE);
        p1_in = d;
        tick(4);
        pulse_prog(2);
        count_busy(200, busy);
    endtask

    task automatic read_at(input string tag, input int a,
                           input logic [7:0] exp);
        set_mode(M_READ);
        goto(a);
        tick(4);
        check(tag, {23'd0, p1_oe, p1_out}, {23'd0, 1'b1, exp});
    endtask

    initial begin
        rst_n = 1'b0; vpp = 1'b0; xtal1 = 1'b0; prog_n = 1'b1;
        set_mode(M_SIG); p1_in = 8'h00;
        tick(3);
        check("rst_p1_out", p1_out, 8'h00);
        check("rst_p1_oe", p1_oe, 1'b0);
        check("rst_rdy", rdy, 1'b1);
        check("rst_addr", addr, 11'd0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        tick(2);

        vpp = 1'b1;
        tick(5);
        do_write(0, 8'hA5, n);
        check("write_busy", n, 24);
        check("write_err", err, 1'b0);
        read_at("read_a5", 0, 8'hA5);

        vpp_restart();
        goto(2047);
        check("addr_7ff", addr, 11'h7FF);
        do_write(2047, 8'h3C, n);
        read_at("read_7ff", 2047, 8'h3C);
        goto(0);
        check("addr_wrap", addr, 11'd0);

        set_mode(M_LOCK2);
        tick(4);
        pulse_prog(2);
        tick(4);
        set_mode(M_ERASE);
        tick(4);
        pulse_prog(300);
        count_busy(3000, n);
        check("erase_busy", n, 2048);
        check("erase_err", err, 1'b0);
        read_at("erased_0", 0, 8'hFF);
        read_at("erased_5", 5, 8'hFF);
        read_at("erased_7ff", 2047, 8'hFF);

        vpp_restart();
        set_mode(M_SIG);
        tick(5);
        check("sig0", {p1_oe, p1_out}, {1'b1, 8'h1E});
        goto(1);
        tick(2);
        check("sig1", p1_out, 8'h21);
        goto(2);
        tick(2);
        check("sig2", p1_out, 8'hFF);

        do_write(6, 8'h12, n);
        read_at("read_12", 6, 8'h12);
        vpp_restart();
        set_mode(M_LOCK1);
        tick(4);
        pulse_prog(2);
        tick(4);
        do_write(5, 8'h00, n);
        check("lock1_busy", n, 24);
        read_at("lock1_read", 5, 8'hFF);
        read_at("lock1_old", 6, 8'h12);
        set_mode(M_LOCK2);
        tick(4);
        pulse_prog(2);
        tick(4);
        vpp_restart();
        read_at("lock2_read", 6, 8'hFF);
        check("lock_err", err, 1'b0);

        set_mode(M_ERASE);
        tick(4);
        pulse_prog(300);
        count_busy(3000, n);
        check("erase2_busy", n, 2048);
        vpp_restart();
        do_write(5, 8'h00, n);
        read_at("unlock_write", 5, 8'h00);
        read_at("unlock_6", 6, 8'hFF);

        set_mode(M_ERASE);
        tick(4);
        pulse_prog(100);
        count_busy(3000, n);
        check("short_busy", n, 0);
        check("short_err", err, 1'b1);
        read_at("short_keep", 5, 8'h00);

        vpp_restart();
        do_write(999, 8'h99, n);
        do_write(1000, 8'h55, n);
        do_write(1001, 8'hAA, n);
        set_mode(M_ERASE);
        tick(4);
        pulse_prog(300);
        n = 0;
        while (rdy && n < 50) begin
            @(negedge osc);
            n++;
        end
        check("sweep_start", rdy, 1'b0);
        repeat (1000) @(posedge osc);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_rdy", rdy, 1'b1);
        check("abort_err", err, 1'b0);
        check("abort_addr", addr, 11'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        cur = 0;
        read_at("abort_5", 5, 8'hFF);
        read_at("abort_999", 999, 8'hFF);
        read_at("abort_1000", 1000, 8'h55);
        read_at("abort_1001", 1001, 8'hAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
